div_seq_ctrl: RTL and testbench



---
 rtl/div_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_div_seq_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// Radix-2 restoring divider sequencer for the EX-stage DIV/DIVU path.
// Stalls the pipeline while iterating, then pulses hi/lo write-enables with remainder/quotient.
module div_seq_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_div,
  input  logic [DATA_W-1:0] opdata1,
  input  logic [DATA_W-1:0] opdata2,
  input  logic              annul,
  output logic              stallreq,
  output logic              ready,
  output logic              hi_we,
  output logic              lo_we,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt_r;
  logic              neg1_r, neg2_r;
  logic [DATA_W-1:0] dvd_r, dsr_r, rem_r, op1_raw_r;

  logic [DATA_W:0]          shifted;
  logic signed [DATA_W+1:0] trial;
  logic                     qbit;
  logic [DATA_W-1:0]        rem_nxt, quo_nxt;

  // Unsigned magnitude; the most negative value maps onto itself as an unsigned number.
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v, input logic en);
    logic [DATA_W-1:0] u;
    u = v;
    return (en && v[DATA_W-1]) ? (~u + 1'b1) : u;
  endfunction

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  // One restoring step: remainder needs DATA_W+1 bits after the shift, plus a borrow bit.
  always_comb begin
    shifted = {rem_r, dvd_r[DATA_W-1]};
    trial   = $signed({1'b0, shifted}) - $signed({2'b00, dsr_r});
    qbit    = ~trial[DATA_W+1];
    rem_nxt = qbit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
    quo_nxt = {dvd_r[DATA_W-2:0], qbit};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (opdata2 == '0) ? DIVZERO : ON;
      DIVZERO: state_nxt = END;
      ON:      if (cnt_r == CNT_LAST) state_nxt = END;
      END:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (annul) state_nxt = IDLE;
  end

  // Operand/iteration registers; sign fix-up lands on the final ON edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= '0;
      neg1_r    <= 1'b0;
      neg2_r    <= 1'b0;
      dvd_r     <= '0;
      dsr_r     <= '0;
      rem_r     <= '0;
      op1_raw_r <= '0;
    end else if (!annul) begin
      case (state)
        IDLE: if (start) begin
          neg1_r    <= signed_div & opdata1[DATA_W-1];
          neg2_r    <= signed_div & opdata2[DATA_W-1];
          dvd_r     <= mag($signed(opdata1), signed_div);
          dsr_r     <= mag($signed(opdata2), signed_div);
          op1_raw_r <= opdata1;
          rem_r     <= '0;
          cnt_r     <= '0;
        end
        ON: begin
          cnt_r <= cnt_r + 1'b1;
          if (cnt_r == CNT_LAST) begin
            dvd_r <= neg_if(quo_nxt, neg1_r ^ neg2_r);
            rem_r <= neg_if(rem_nxt, neg1_r);
          end else begin
            dvd_r <= quo_nxt;
            rem_r <= rem_nxt;
          end
        end
        DIVZERO: begin
          dvd_r <= '1;
          rem_r <= op1_raw_r;
        end
        default: ;
      endcase
    end
  end

  assign stallreq = ~rst & (((state == IDLE) & start & ~annul) | (state == ON) | (state == DIVZERO));
  assign ready    = (state == END);
  assign hi_we    = ready;
  assign lo_we    = ready;
  assign hi_o     = ready ? rem_r : '0;
  assign lo_o     = ready ? dvd_r : '0;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed self-checking bench for div_seq_ctrl (DATA_W=32).
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, signed_div, annul;
  logic [31:0] opdata1, opdata2;
  logic        stallreq, ready, hi_we, lo_we;
  logic [31:0] hi_o, lo_o;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .opdata1(opdata1), .opdata2(opdata2), .annul(annul),
    .stallreq(stallreq), .ready(ready), .hi_we(hi_we), .lo_we(lo_we),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one divide in the current (IDLE) cycle, waits for ready, checks the result.
  task automatic run_div(input string tag, input logic sd, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi, input int lat,
                         output int ready_time);
    int  n;
    int  stall_bad;
    bit  seen;
    signed_div = sd;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    #1;
    chk({tag, " stall_first"}, {31'd0, stallreq}, 32'd1);
    n = 0; seen = 0; stall_bad = 0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (ready) seen = 1;
      else if (!stallreq) stall_bad++;
    end
    ready_time = n;
    chk({tag, " latency"}, n, lat);
    chk({tag, " stall_held"}, stall_bad, 0);
    chk({tag, " lo"}, lo_o, exp_lo);
    chk({tag, " hi"}, hi_o, exp_hi);
    chk({tag, " we"}, {30'd0, hi_we, lo_we}, 32'd3);
    chk({tag, " stall_end"}, {31'd0, stallreq}, 32'd0);
    start = 1'b0;
  endtask

  initial begin
    int rt, rt2, pulses;

    rst = 1'b1; start = 1'b1; signed_div = 1'b0; annul = 1'b0;
    opdata1 = 32'd5; opdata2 = 32'd1;
    tick(); tick();
    chk("rst stallreq", {31'd0, stallreq}, 32'd0);
    chk("rst outs", {30'd0, ready, hi_we} | hi_o | lo_o, 32'd0);
    start = 1'b0; rst = 1'b0;
    tick();
    chk("idle stallreq", {31'd0, stallreq}, 32'd0);

    run_div("divu100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, rt);
    tick();
    chk("divu100_7 ready_drop", {31'd0, ready}, 32'd0);
    chk("divu100_7 lo_zero", lo_o, 32'd0);

    tick();
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, rt);
    tick();
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, rt);
    tick();
    run_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 33, rt);
    tick();
    run_div("divu_z", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 2, rt);
    tick();
    run_div("div_z_neg", 1'b1, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF00, 2, rt);
    tick();
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, rt);
    tick();
    run_div("divu_ovf_pat", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, rt);
    tick();
    run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33, rt);
    tick();

    // Flush during the 10th ON cycle.
    signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("annul stall_on", {31'd0, stallreq}, 32'd1);
    annul = 1'b1; start = 1'b0;
    tick();
    annul = 1'b0;
    #1;
    chk("annul stall_after", {31'd0, stallreq}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready || hi_we || lo_we) pulses++;
      tick();
    end
    chk("annul no_ready", pulses, 0);
    run_div("divu9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, rt);
    tick();

    // Reset in the middle of ON.
    signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd5; start = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1; start = 1'b0;
    #1;
    chk("midrst stall", {31'd0, stallreq}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst outs", {29'd0, ready, hi_we, stallreq} | hi_o | lo_o, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready) pulses++;
      tick();
    end
    chk("midrst no_ready", pulses, 0);

    // Back-to-back: second start in the IDLE cycle right after END.
    run_div("b2b_10_3", 1'b0, 32'd10, 32'd3, 32'd3, 32'd1, 33, rt);
    rt = 0;
    tick();
    run_div("b2b_20_6", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 33, rt2);
    chk("b2b spacing", rt2 + 1, 34);
    tick();
    chk("b2b final_idle", {30'd0, ready, stallreq}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
